// File: rtl/mem_arbiter_if.sv
// Bundle shared by mem_arbiter: both caches' memory-side ports plus the memory slave port.
// master = arbiter view, slave = environment (caches + memory) view.
interface mem_arbiter_if #(
  parameter int LINE_SIZE    = 32,
  parameter int BLOCK_SIZE   = 2,
  parameter int ADDRESS_SIZE = 32
);
  localparam int BW = (1 << BLOCK_SIZE) * LINE_SIZE;
  localparam int AW = ADDRESS_SIZE - BLOCK_SIZE - 2;

  logic          r0_read_i;
  logic          r0_wr_i;
  logic [AW-1:0] r0_addr_i;
  logic [BW-1:0] r0_wdata_i;
  logic          r0_busywait_o;
  logic [BW-1:0] r0_rdata_o;
  logic          r0_read_done_o;
  logic          r0_write_done_o;

  logic          r1_read_i;
  logic          r1_wr_i;
  logic [AW-1:0] r1_addr_i;
  logic [BW-1:0] r1_wdata_i;
  logic          r1_busywait_o;
  logic [BW-1:0] r1_rdata_o;
  logic          r1_read_done_o;
  logic          r1_write_done_o;

  logic          m_read_o;
  logic          m_wr_o;
  logic [AW-1:0] m_addr_o;
  logic [BW-1:0] m_wdata_o;
  logic          m_busywait_i;
  logic [BW-1:0] m_rdata_i;
  logic          m_read_done_i;
  logic          m_write_done_i;

  modport master (
    input  r0_read_i, r0_wr_i, r0_addr_i, r0_wdata_i,
    output r0_busywait_o, r0_rdata_o, r0_read_done_o, r0_write_done_o,
    input  r1_read_i, r1_wr_i, r1_addr_i, r1_wdata_i,
    output r1_busywait_o, r1_rdata_o, r1_read_done_o, r1_write_done_o,
    output m_read_o, m_wr_o, m_addr_o, m_wdata_o,
    input  m_busywait_i, m_rdata_i, m_read_done_i, m_write_done_i
  );

  modport slave (
    output r0_read_i, r0_wr_i, r0_addr_i, r0_wdata_i,
    input  r0_busywait_o, r0_rdata_o, r0_read_done_o, r0_write_done_o,
    output r1_read_i, r1_wr_i, r1_addr_i, r1_wdata_i,
    input  r1_busywait_o, r1_rdata_o, r1_read_done_o, r1_write_done_o,
    input  m_read_o, m_wr_o, m_addr_o, m_wdata_o,
    output m_busywait_i, m_rdata_i, m_read_done_i, m_write_done_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port block-memory arbiter (port 0 = I-cache, port 1 = D-cache), one transaction at a time.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on ties instead of fixed port-0 priority.
module mem_arbiter #(
  parameter int LINE_SIZE    = 32,
  parameter int BLOCK_SIZE   = 2,
  parameter int ADDRESS_SIZE = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  mem_arbiter_if.master bus
);
  localparam int BW = (1 << BLOCK_SIZE) * LINE_SIZE;
  localparam int AW = ADDRESS_SIZE - BLOCK_SIZE - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state_r;
  logic   grant_r;
  logic   last_grant_r;
  logic   op_wr_r;
  logic   m_read_r;
  logic   m_wr_r;

  logic   req0_s;
  logic   req1_s;
  logic   next_grant_s;
  logic   next_wr_s;
  logic   done_hit_s;
  logic   in_access_s;
  logic   rd_fwd_s;
  logic   wr_fwd_s;

  // Request decode and winner selection for the next grant.
  always_comb begin
    req0_s       = bus.r0_read_i | bus.r0_wr_i;
    req1_s       = bus.r1_read_i | bus.r1_wr_i;
    next_grant_s = 1'b0;
    if (req0_s && req1_s) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      next_grant_s = ~last_grant_r;
`else
      // last_grant is still tracked here; fixed priority simply ignores it
      next_grant_s = 1'b0 & last_grant_r;
`endif
    end else if (req1_s) begin
      next_grant_s = 1'b1;
    end else begin
      next_grant_s = 1'b0;
    end
    // A simultaneous read+write strobe is served as a write
    next_wr_s  = next_grant_s ? bus.r1_wr_i : bus.r0_wr_i;
    done_hit_s = op_wr_r ? bus.m_write_done_i : bus.m_read_done_i;
  end

  // Arbitration FSM with registered memory strobes.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      op_wr_r      <= 1'b0;
      m_read_r     <= 1'b0;
      m_wr_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req0_s || req1_s) begin
            grant_r      <= next_grant_s;
            last_grant_r <= next_grant_s;
            op_wr_r      <= next_wr_s;
            m_wr_r       <= next_wr_s;
            m_read_r     <= ~next_wr_s;
            state_r      <= ACCESS;
          end else begin
            m_read_r <= 1'b0;
            m_wr_r   <= 1'b0;
          end
        end
        ACCESS: begin
          if (done_hit_s) begin
            m_read_r <= 1'b0;
            m_wr_r   <= 1'b0;
            state_r  <= RELEASE;
          end else begin
            state_r <= ACCESS;
          end
        end
        RELEASE: begin
          // One dead cycle lets the served cache drop its request
          m_read_r <= 1'b0;
          m_wr_r   <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          m_read_r <= 1'b0;
          m_wr_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  // Memory-side mux and done/rdata routing back to the granted cache only.
  always_comb begin
    in_access_s   = (state_r == ACCESS);
    rd_fwd_s      = in_access_s & bus.m_read_done_i & ~op_wr_r;
    wr_fwd_s      = in_access_s & bus.m_write_done_i & op_wr_r;

    bus.m_read_o  = m_read_r;
    bus.m_wr_o    = m_wr_r;
    if (in_access_s) begin
      bus.m_addr_o  = grant_r ? bus.r1_addr_i  : bus.r0_addr_i;
      bus.m_wdata_o = grant_r ? bus.r1_wdata_i : bus.r0_wdata_i;
    end else begin
      bus.m_addr_o  = {AW{1'b0}};
      bus.m_wdata_o = {BW{1'b0}};
    end

    bus.r0_read_done_o  = rd_fwd_s & ~grant_r;
    bus.r0_write_done_o = wr_fwd_s & ~grant_r;
    bus.r1_read_done_o  = rd_fwd_s & grant_r;
    bus.r1_write_done_o = wr_fwd_s & grant_r;

    if (in_access_s && !grant_r) begin
      bus.r0_rdata_o = bus.m_rdata_i;
    end else begin
      bus.r0_rdata_o = {BW{1'b0}};
    end
    if (in_access_s && grant_r) begin
      bus.r1_rdata_o = bus.m_rdata_i;
    end else begin
      bus.r1_rdata_o = {BW{1'b0}};
    end

    bus.r0_busywait_o = req0_s & ~(bus.r0_read_done_o | bus.r0_write_done_o);
    bus.r1_busywait_o = req1_s & ~(bus.r1_read_done_o | bus.r1_write_done_o);
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus hand sequences for collisions and reset.
module tb_mem_arbiter;
  logic clk;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         r0_rd;
    logic         r0_wr;
    logic [27:0]  r0_addr;
    logic [127:0] r0_wdata;
    logic         r1_rd;
    logic         r1_wr;
    logic [27:0]  r1_addr;
    logic [127:0] r1_wdata;
    int           lat;
    logic [127:0] rdata;
    logic         exp_port;
    logic         exp_wr;
    logic [27:0]  exp_addr;
    logic [127:0] exp_wdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.r0_read_i = 1'b0; bus.r0_wr_i = 1'b0; bus.r0_addr_i = 28'd0; bus.r0_wdata_i = 128'd0;
    bus.r1_read_i = 1'b0; bus.r1_wr_i = 1'b0; bus.r1_addr_i = 28'd0; bus.r1_wdata_i = 128'd0;
    bus.m_busywait_i = 1'b0; bus.m_rdata_i = 128'd0;
    bus.m_read_done_i = 1'b0; bus.m_write_done_i = 1'b0;
  endtask

  function automatic logic [3:0] dones();
    return {bus.r0_read_done_o, bus.r0_write_done_o, bus.r1_read_done_o, bus.r1_write_done_o};
  endfunction

  // Called at a negedge with the arbiter idle; returns at a negedge with it idle again.
  task automatic run_vec(input vec_t v, input int idx);
    logic       req0, req1;
    logic [3:0] ed;
    req0 = v.r0_rd | v.r0_wr;
    req1 = v.r1_rd | v.r1_wr;
    ed = v.exp_port ? (v.exp_wr ? 4'b0001 : 4'b0010) : (v.exp_wr ? 4'b0100 : 4'b1000);
    bus.r0_read_i = v.r0_rd; bus.r0_wr_i = v.r0_wr; bus.r0_addr_i = v.r0_addr; bus.r0_wdata_i = v.r0_wdata;
    bus.r1_read_i = v.r1_rd; bus.r1_wr_i = v.r1_wr; bus.r1_addr_i = v.r1_addr; bus.r1_wdata_i = v.r1_wdata;
    @(posedge clk); #1;
    chk($sformatf("v%0d_strobes", idx), {bus.m_read_o, bus.m_wr_o}, {~v.exp_wr, v.exp_wr});
    chk($sformatf("v%0d_addr", idx), bus.m_addr_o, v.exp_addr);
    chk($sformatf("v%0d_wdata", idx), bus.m_wdata_o, v.exp_wdata);
    chk($sformatf("v%0d_busy_wait", idx), {bus.r0_busywait_o, bus.r1_busywait_o}, {req0, req1});
    @(negedge clk);
    bus.m_rdata_i = v.rdata;
    if (v.exp_wr) bus.m_read_done_i = 1'b1; else bus.m_write_done_i = 1'b1;
    #1;
    chk($sformatf("v%0d_wrong_done_ignored", idx), dones(), 4'b0000);
    @(posedge clk); #1;
    bus.m_read_done_i = 1'b0; bus.m_write_done_i = 1'b0;
    chk($sformatf("v%0d_hold", idx), {bus.m_read_o, bus.m_wr_o}, {~v.exp_wr, v.exp_wr});
    repeat (v.lat - 2) @(posedge clk);
    @(negedge clk);
    if (v.exp_wr) bus.m_write_done_i = 1'b1; else bus.m_read_done_i = 1'b1;
    #1;
    chk($sformatf("v%0d_done", idx), dones(), ed);
    chk($sformatf("v%0d_rdata0", idx), bus.r0_rdata_o, v.exp_port ? 128'd0 : v.rdata);
    chk($sformatf("v%0d_rdata1", idx), bus.r1_rdata_o, v.exp_port ? v.rdata : 128'd0);
    chk($sformatf("v%0d_busy_done", idx), {bus.r0_busywait_o, bus.r1_busywait_o},
        {req0 & v.exp_port, req1 & ~v.exp_port});
    @(posedge clk); #1;
    chk($sformatf("v%0d_release", idx), {bus.m_read_o, bus.m_wr_o, dones()}, 6'b000000);
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [27:0] exp_seq [4];

  initial begin
    // r0 rd, r0 wr, r0 addr, r0 wdata, r1 rd, r1 wr, r1 addr, r1 wdata, lat, rdata, port, wr, addr, wdata
    vecs[0] = '{1'b0, 1'b0, 28'h0, 128'h0, 1'b1, 1'b0, 28'h0000001, 128'h0, 2,
                128'h1111, 1'b1, 1'b0, 28'h0000001, 128'h0};
    vecs[1] = '{1'b1, 1'b0, 28'h0000003, 128'h0, 1'b0, 1'b0, 28'h0, 128'h0, 5,
                128'h0000_0004_0000_0003_0000_0002_0000_0001, 1'b0, 1'b0, 28'h0000003, 128'h0};
    vecs[2] = '{1'b0, 1'b1, 28'h0000004, 128'hA5A5, 1'b0, 1'b0, 28'h0, 128'h0, 3,
                128'h0, 1'b0, 1'b1, 28'h0000004, 128'hA5A5};
    vecs[3] = '{1'b0, 1'b0, 28'h0, 128'h0, 1'b1, 1'b1, 28'h0000009, 128'h99, 2,
                128'h0, 1'b1, 1'b1, 28'h0000009, 128'h99};
    vecs[4] = '{1'b1, 1'b0, 28'h0000005, 128'h0, 1'b0, 1'b1, 28'h0000006, 128'h38, 3,
                128'hBEEF, 1'b0, 1'b0, 28'h0000005, 128'h0};
    vecs[5] = '{1'b1, 1'b1, 28'h000000A, 128'h77, 1'b0, 1'b0, 28'h0, 128'h0, 2,
                128'h0, 1'b0, 1'b1, 28'h000000A, 128'h77};
    vecs[6] = '{1'b0, 1'b0, 28'h0, 128'h0, 1'b1, 1'b0, 28'hFFFFFFF, 128'h0, 3,
                {128{1'b1}}, 1'b1, 1'b0, 28'hFFFFFFF, 128'h0};

    clear_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_ctrl", {bus.r0_busywait_o, bus.r1_busywait_o, dones(), bus.m_read_o, bus.m_wr_o}, 8'h00);
    chk("reset_addr", bus.m_addr_o, 28'h0);
    chk("reset_wdata", bus.m_wdata_o, 128'h0);
    chk("reset_rdata", {bus.r0_rdata_o[63:0], bus.r1_rdata_o[63:0]}, 128'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Collision: r0 read wins, r1 write is granted right after RELEASE/IDLE
    bus.r0_read_i = 1'b1; bus.r0_addr_i = 28'h0000005;
    bus.r1_wr_i = 1'b1; bus.r1_addr_i = 28'h0000006; bus.r1_wdata_i = 128'h38;
    @(posedge clk); #1;
    chk("col_first", {bus.m_read_o, bus.m_wr_o, bus.m_addr_o}, {2'b10, 28'h0000005});
    chk("col_r1_busy", bus.r1_busywait_o, 1'b1);
    @(negedge clk);
    bus.m_read_done_i = 1'b1; bus.m_rdata_i = 128'h5555;
    #1;
    chk("col_r0_done", {dones(), bus.r1_busywait_o, bus.r1_rdata_o[15:0]}, {4'b1000, 1'b1, 16'h0});
    @(posedge clk); #1;
    chk("col_release", {bus.m_read_o, bus.m_wr_o, bus.r1_busywait_o}, 3'b001);
    @(negedge clk);
    bus.m_read_done_i = 1'b0; bus.r0_read_i = 1'b0;
    @(posedge clk); #1;
    chk("col_idle", {bus.m_read_o, bus.m_wr_o}, 2'b00);
    @(posedge clk); #1;
    chk("col_second", {bus.m_read_o, bus.m_wr_o, bus.m_addr_o}, {2'b01, 28'h0000006});
    chk("col_second_wdata", bus.m_wdata_o, 128'h38);
    @(negedge clk);
    bus.m_write_done_i = 1'b1;
    #1;
    chk("col_r1_done", {dones(), bus.r1_busywait_o}, {4'b0001, 1'b0});
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    @(negedge clk);

    // Both ports requesting continuously for four transactions
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{28'h10, 28'h20, 28'h10, 28'h20};
`else
    exp_seq = '{28'h10, 28'h10, 28'h10, 28'h10};
`endif
    bus.r0_read_i = 1'b1; bus.r0_addr_i = 28'h10;
    bus.r1_read_i = 1'b1; bus.r1_addr_i = 28'h20;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("seq%0d_grant", k), {bus.m_read_o, bus.m_addr_o}, {1'b1, exp_seq[k]});
      @(negedge clk);
      bus.m_read_done_i = 1'b1;
      #1;
      chk($sformatf("seq%0d_done", k), dones(), (exp_seq[k] == 28'h10) ? 4'b1000 : 4'b0010);
      @(posedge clk);
      @(negedge clk);
      bus.m_read_done_i = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of an access
    bus.r0_read_i = 1'b1; bus.r0_addr_i = 28'h0000007;
    @(posedge clk); #1;
    chk("rst_mid_access", bus.m_read_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_strobe_drop", {bus.m_read_o, bus.m_wr_o}, 2'b00);
    bus.m_read_done_i = 1'b1; bus.m_rdata_i = 128'h7777;
    #1;
    chk("rst_mid_no_done", {dones(), bus.r0_rdata_o[15:0]}, {4'b0000, 16'h0});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    chk("rst_mid_idle", {bus.m_read_o, bus.m_wr_o}, 2'b00);
    @(negedge clk);
    bus.r1_read_i = 1'b1; bus.r1_addr_i = 28'h0000008;
    @(posedge clk); #1;
    chk("rst_mid_regrant", {bus.m_read_o, bus.m_addr_o}, {1'b1, 28'h0000008});
    @(negedge clk);
    bus.m_read_done_i = 1'b1;
    #1;
    chk("rst_mid_regrant_done", dones(), 4'b0010);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single block-wide data memory between the instruction cache (port 0) and the data cache (port 1).
- Sits between both caches' memory-side interfaces (read/write strobes, block address, block data, done pulses) and the memory's slave interface.
- Grants one block transaction at a time, holds the grant until the memory's done pulse, and routes done and read data back to the granted cache only.

Parameters:
- LINE_SIZE, 32, word width in bits.
- BLOCK_SIZE, 2, log2 of words per block; block width BW = 2**BLOCK_SIZE*LINE_SIZE = 128.
- ADDRESS_SIZE, 32, CPU byte address width; block address width AW = ADDRESS_SIZE-BLOCK_SIZE-2 = 28.

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- r0_read_i  in  1  port 0 block read request; held until r0_read_done_o
- r0_wr_i  in  1  port 0 block write request; held until r0_write_done_o
- r0_addr_i  in  AW  port 0 block address
- r0_wdata_i  in  BW  port 0 write block
- r0_busywait_o  out  1  port 0 stalled
- r0_rdata_o  out  BW  port 0 read block
- r0_read_done_o  out  1  port 0 read complete, 1-cycle pulse
- r0_write_done_o  out  1  port 0 write complete, 1-cycle pulse
- r1_* (same eight ports)  —  port 1 equivalents
- m_read_o  out  1  memory read strobe
- m_wr_o  out  1  memory write strobe
- m_addr_o  out  AW  memory block address
- m_wdata_o  out  BW  memory write block
- m_busywait_i  in  1  memory busy
- m_rdata_i  in  BW  memory read block
- m_read_done_i  in  1  memory read done pulse
- m_write_done_i  in  1  memory write done pulse

Behaviour:
- Reset:
  - State IDLE, grant = 0, last_grant = 1.
  - All outputs 0, including m_read_o, m_wr_o, m_addr_o, m_wdata_o, done pulses and rdata.
  - Reset mid-transaction drops memory strobes immediately and discards the transaction; no done pulse is issued.
- Per-port request: req_n = rN_read_i | rN_wr_i.
  - If both strobes are high, the access is treated as a write and the read is ignored.
- State IDLE:
  - Memory strobes are 0.
  - On a clock edge with any req_n, latch grant (policy below), latch op (write if rN_wr_i, else read), and go to ACCESS.
  - With no request, stay in IDLE.
- State ACCESS:
  - m_read_o/m_wr_o are driven from the latched op.
  - m_addr_o/m_wdata_o are muxed combinationally from the granted port's inputs, which requesters hold stable.
  - On a done pulse matching the latched op, go to RELEASE; otherwise stay.
  - A mismatched done pulse is ignored. m_busywait_i is informational only and does not advance the FSM.
- State RELEASE:
  - Memory strobes are 0 for exactly one cycle, then go to IDLE.
  - This gives the granted cache time to drop its request so it is not re-granted.
- Done routing (combinational, same cycle as the memory pulse, ACCESS only):
  - rN_read_done_o = m_read_done_i & grant==N & op==read.
  - rN_write_done_o = m_write_done_i & grant==N & op==write.
  - rN_rdata_o = m_rdata_i when grant==N, else 0.
- rN_busywait_o = req_n & ~(rN_read_done_o | rN_write_done_o). A waiting (ungranted) port sees busywait high throughout.
- Grant policy (default): fixed priority, port 0 wins ties. last_grant is updated on every grant.
- Minimum transaction cost: memory latency + 2 cycles (grant edge, RELEASE). Back-to-back requests from the other port are granted on the edge leaving IDLE.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, grant goes to the port != last_grant; a single requester is granted regardless of last_grant.
- Undefined: fixed priority, port 0 always wins ties; last_grant is kept but unused.

Test Plan:
- Reset: reset_i pulsed at t=1ns → all outputs 0, FSM IDLE; port 1 read to 0x0000001 is granted on the first edge after release.
- Single read: r0 read addr 0x0000003, memory returns 128'h...0004_0003_0002_0001 after 5 cycles → m_read_o high until the done pulse; r0_read_done_o is a 1-cycle pulse with r0_rdata_o equal to that value; r1 outputs remain 0.
- Collision, fixed priority: r0 read 0x0000005 and r1 write 0x0000006 (wdata 128'h38) asserted on the same edge → r0 served first; r1_busywait_o stays high; after r0 done plus RELEASE, m_wr_o high with m_addr_o=0x0000006 and m_wdata_o=128'h38.
- Collision with MEM_ARB_ROUND_ROBIN_EN: both ports request continuously for 4 transactions → grant sequence 0,1,0,1; without the macro → 0,0,0,0 while r0 keeps requesting.
- Rd+wr on the same port: r1 asserts both strobes for 0x0000009 → only m_wr_o goes high and only r1_write_done_o pulses.
- Reset mid-access: assert reset_i while in ACCESS with m_read_o=1 → m_read_o falls asynchronously, no done pulse is forwarded, FSM is in IDLE after reset deasserts.
